fetch_unit: RTL and testbench

//   Instruction fetch stage that sits directly upstream of the memory block.

---
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, single-outstanding memory reads, show-ahead buffer
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module fetch_unit #(
  parameter logic [`ADDRESS_WIDTH-1:0] RESET_PC   = '0,
  parameter int                        FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_redirect,
  input  logic [`ADDRESS_WIDTH-1:0] i_redirect_pc,
  output logic [`ADDRESS_WIDTH-1:0] o_mem_address,
  output logic [`DATA_WIDTH-1:0]    o_mem_data,
  output logic                      o_mem_valid,
  output logic                      o_mem_cmd,
  input  logic                      i_mem_ready,
  input  logic [`DATA_WIDTH-1:0]    i_mem_data,
  input  logic                      i_mem_res_valid,
  output logic                      o_mem_res_ready,
  output logic [`DATA_WIDTH-1:0]    o_inst,
  output logic [`ADDRESS_WIDTH-1:0] o_inst_pc,
  output logic                      o_inst_valid,
  input  logic                      i_inst_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t                    state, state_d;
  logic [`ADDRESS_WIDTH-1:0] pc, pc_d;
  logic [`ADDRESS_WIDTH-1:0] req_pc, req_pc_d;
  logic                      drop, drop_d;

  logic [`DATA_WIDTH-1:0]    fifo_data [FIFO_DEPTH];
  logic [`ADDRESS_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          count;

  logic req_fire, res_fire, push, pop;

  assign o_mem_data      = '0;
  assign o_mem_cmd       = 1'b0;
  assign o_mem_address   = pc;
  // Issuing only with a free slot guarantees the response always has room.
  assign o_mem_valid     = !reset && (state == S_REQ) && (count < CNT_W'(FIFO_DEPTH));
  assign o_mem_res_ready = !reset && (state == S_WAIT);
  assign o_inst_valid    = !reset && (count != '0);
  assign o_inst          = fifo_data[rd_ptr];
  assign o_inst_pc       = fifo_pc[rd_ptr];

  assign req_fire = o_mem_valid && i_mem_ready;
  assign res_fire = i_mem_res_valid && o_mem_res_ready;
  assign push     = res_fire && !drop && !i_redirect;
  assign pop      = o_inst_valid && i_inst_ready && !i_redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      drop   <= 1'b0;
    end else begin
      state  <= state_d;
      pc     <= pc_d;
      req_pc <= req_pc_d;
      drop   <= drop_d;
    end
  end

  always_comb begin
    state_d  = state;
    pc_d     = pc;
    req_pc_d = req_pc;
    drop_d   = drop;
    case (state)
      S_REQ: begin
        if (req_fire) begin
          req_pc_d = pc;
          pc_d     = pc + `ADDRESS_WIDTH'(`DATA_WIDTH / 8);
          state_d  = S_WAIT;
        end
        if (i_redirect) begin
          pc_d = i_redirect_pc;
          // A request already accepted by memory cannot be recalled; discard its reply.
          if (req_fire) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (res_fire) begin
          drop_d  = 1'b0;
          state_d = S_REQ;
        end else if (i_redirect) begin
          drop_d = 1'b1;
        end
        if (i_redirect) pc_d = i_redirect_pc;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= i_mem_data;
      fifo_pc[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic [31:0] o_mem_address;
  logic [31:0] o_mem_data;
  logic        o_mem_valid;
  logic        o_mem_cmd;
  logic        i_mem_ready;
  logic [31:0] i_mem_data;
  logic        i_mem_res_valid;
  logic        o_mem_res_ready;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        o_inst_valid;
  logic        i_inst_ready = 1'b0;

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_mem_address(o_mem_address), .o_mem_data(o_mem_data),
    .o_mem_valid(o_mem_valid), .o_mem_cmd(o_mem_cmd),
    .i_mem_ready(i_mem_ready), .i_mem_data(i_mem_data),
    .i_mem_res_valid(i_mem_res_valid), .o_mem_res_ready(o_mem_res_ready),
    .o_inst(o_inst), .o_inst_pc(o_inst_pc),
    .o_inst_valid(o_inst_valid), .i_inst_ready(i_inst_ready)
  );

  always #5 clk = ~clk;

  // Memory model: one outstanding read, response after mem_delay cycles, optionally stalled.
  logic [31:0] mem [0:255];
  int          mem_delay = 1;
  logic        mem_stall = 1'b0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr = '0;
  int          overlap_err = 0;

  assign i_mem_ready     = 1'b1;
  assign i_mem_res_valid = pend && (cnt == 0) && !mem_stall;
  assign i_mem_data      = mem[pend_addr[9:2]];

  always @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
      cnt  <= 0;
    end else begin
      if (i_mem_res_valid && o_mem_res_ready) pend <= 1'b0;
      else if (cnt > 0) cnt <= cnt - 1;
      if (o_mem_valid && i_mem_ready) begin
        if (pend && !(i_mem_res_valid && o_mem_res_ready)) overlap_err <= overlap_err + 1;
        pend      <= 1'b1;
        cnt       <= mem_delay - 1;
        pend_addr <= o_mem_address;
      end
    end
  end

  logic [31:0] req_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_data_q[$];

  always @(posedge clk) begin
    if (!reset) begin
      if (o_mem_valid && i_mem_ready) req_q.push_back(o_mem_address);
      if (o_inst_valid && i_inst_ready && !i_redirect) begin
        pop_pc_q.push_back(o_inst_pc);
        pop_data_q.push_back(o_inst);
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    req_q.delete();
    pop_pc_q.delete();
    pop_data_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_stall = 1'b0;
    @(negedge clk);
    clear_q();
    reset = 1'b0;
  endtask

  task automatic wait_pops(input int n, input string tag);
    int budget = 200;
    while (pop_pc_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(tag, 64'(pop_pc_q.size() >= n), 64'd1);
  endtask

  task automatic check_pop(input int idx, input logic [31:0] pc, input string tag);
    if (pop_pc_q.size() > idx) begin
      check({tag, "_pc"}, 64'(pop_pc_q[idx]), 64'(pc));
      check({tag, "_data"}, 64'(pop_data_q[idx]), 64'(mem[pc[9:2]]));
    end else begin
      check({tag, "_missing"}, 64'd0, 64'd1);
    end
  endtask

  initial begin
    int viol;
    int budget;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + i;
    mem[0]    = 32'h11;
    mem[1]    = 32'h22;
    mem[2]    = 32'h33;
    mem[8'h40] = 32'h40;
    mem[8'h80] = 32'h80;

    // Reset state
    @(negedge clk);
    check("rst_mem_valid", 64'(o_mem_valid), 64'd0);
    check("rst_res_ready", 64'(o_mem_res_ready), 64'd0);
    check("rst_inst_valid", 64'(o_inst_valid), 64'd0);
    check("rst_address", 64'(o_mem_address), 64'h0);
    check("mem_cmd", 64'(o_mem_cmd), 64'd0);
    check("mem_wdata", 64'(o_mem_data), 64'd0);

    // 1: sequential fetch with 1-cycle memory, first-word latency
    i_inst_ready = 1'b1;
    mem_delay = 1;
    do_reset();
    @(negedge clk);
    check("t1_lat_valid_n", 64'(o_inst_valid), 64'd0);
    check("t1_lat_wait", 64'(o_mem_res_ready), 64'd1);
    @(negedge clk);
    check("t1_lat_valid_n1", 64'(o_inst_valid), 64'd1);
    check("t1_lat_inst", 64'(o_inst), 64'h11);
    check("t1_lat_pc", 64'(o_inst_pc), 64'h0);
    wait_pops(3, "t1_pops");
    check_pop(0, 32'h0, "t1_0");
    check_pop(1, 32'h4, "t1_1");
    check_pop(2, 32'h8, "t1_2");

    // 2: decode stall fills the buffer, then resumes with no loss or duplication
    i_inst_ready = 1'b0;
    do_reset();
    repeat (10) @(negedge clk);
    check("t2_req_count", 64'(req_q.size()), 64'd2);
    check("t2_mem_valid_off", 64'(o_mem_valid), 64'd0);
    i_inst_ready = 1'b1;
    wait_pops(5, "t2_pops");
    for (int k = 0; k < 5; k++) check_pop(k, 32'(k * 4), $sformatf("t2_%0d", k));

    // 3: redirect while waiting with no response yet
    mem_delay = 2;
    do_reset();
    budget = 50;
    while (!(o_mem_res_ready && !i_mem_res_valid) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("t3_reach_wait", 64'(budget > 0), 64'd1);
    i_redirect = 1'b1;
    i_redirect_pc = 32'h100;
    clear_q();
    @(negedge clk);
    i_redirect = 1'b0;
    check("t3_flushed", 64'(o_inst_valid), 64'd0);
    wait_pops(2, "t3_pops");
    check_pop(0, 32'h100, "t3_0");
    check_pop(1, 32'h104, "t3_1");
    check("t3_first_req", 64'(req_q.size() > 0 ? req_q[0] : 32'hdead), 64'h100);

    // 4: redirect in the same cycle a request fires
    mem_delay = 1;
    do_reset();
    repeat (3) @(negedge clk);
    budget = 50;
    while (!o_mem_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("t4_reach_req", 64'(budget > 0), 64'd1);
    viol = int'(o_mem_address);
    i_redirect = 1'b1;
    i_redirect_pc = 32'h200;
    clear_q();
    @(negedge clk);
    i_redirect = 1'b0;
    wait_pops(1, "t4_pops");
    check_pop(0, 32'h200, "t4_0");
    check("t4_req0_old", 64'(req_q.size() > 0 ? req_q[0] : 32'hdead), 64'(viol));
    check("t4_req1_new", 64'(req_q.size() > 1 ? req_q[1] : 32'hdead), 64'h200);

    // 5: slow, stalled memory keeps a single request outstanding
    mem_delay = 3;
    do_reset();
    mem_stall = 1'b1;
    @(negedge clk);
    viol = 0;
    for (int k = 0; k < 8; k++) begin
      if (o_mem_valid) viol++;
      @(negedge clk);
    end
    check("t5_no_valid_in_wait", 64'(viol), 64'd0);
    check("t5_single_req", 64'(req_q.size()), 64'd1);
    mem_stall = 1'b0;
    wait_pops(2, "t5_pops");
    check_pop(0, 32'h0, "t5_0");
    check_pop(1, 32'h4, "t5_1");
    check("t5_overlap", 64'(overlap_err), 64'd0);

    // 6: reset asserted in WAIT with one buffered entry
    mem_delay = 2;
    i_inst_ready = 1'b0;
    do_reset();
    budget = 50;
    while (!(o_inst_valid && o_mem_res_ready) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("t6_reach_state", 64'(budget > 0), 64'd1);
    reset = 1'b1;
    #1;
    check("t6_inst_valid", 64'(o_inst_valid), 64'd0);
    check("t6_pc_reset", 64'(o_mem_address), 64'h0);
    check("t6_res_ready", 64'(o_mem_res_ready), 64'd0);
    @(negedge clk);
    clear_q();
    reset = 1'b0;
    i_inst_ready = 1'b1;
    wait_pops(1, "t6_pops");
    check("t6_first_req", 64'(req_q.size() > 0 ? req_q[0] : 32'hdead), 64'h0);
    check_pop(0, 32'h0, "t6_0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
